// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset sequencer in the PLL output clock domain. It converts
// the raw, asynchronous PLL lock into an active-low downstream reset with
// synchronous release. Reset releases only after synced lock has stayed high
// for a qualification window and then a hold window. Losing lock while
// running re-asserts reset and is logged in a sticky flag and a counter.
//
// Ports:
//   clk_i       PLL output clock, the only clock
//   rst_ni      asynchronous active-low reset
//   pll_lock_i  raw PLL lock, asynchronous to clk_i
//   clear_i     synchronous pulse: clears lock_lost_o and loss_cnt_o
//   rst_no      downstream reset, active-low, released synchronously
//   ready_o     high while running (same value as rst_no)
//   lock_lost_o sticky flag: lock was lost while running
//   loss_cnt_o  saturating count of lock losses while running
module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOSS_CNT_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pll_lock_i,
  input  logic                  clear_i,
  output logic                  rst_no,
  output logic                  ready_o,
  output logic                  lock_lost_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned MAX_WIN = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;

  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   run_q;
  logic                   lost_q;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q;
  logic                   run_loss_c;

  // Lock synchronizer; the only logic that samples pll_lock_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // A loss only counts when it interrupts RUN; drops during qualification are glitches.
  assign run_loss_c = (state_q == RUN) && !lock_s;

  // Qualification FSM; run_q is registered alongside the state so it is high exactly in RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            run_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  // Loss log; a loss on the same edge as clear_i wins and counts as the first event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else if (run_loss_c) begin
      lost_q <= 1'b1;
      if (clear_i) begin
        loss_cnt_q <= LOSS_CNT_W'(1);
      end else if (loss_cnt_q != LOSS_MAX) begin
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
      end
    end else if (clear_i) begin
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end
  end

  assign rst_no      = run_q;
  assign ready_o     = run_q;
  assign lock_lost_o = lost_q;
  assign loss_cnt_o  = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4,
// LOSS_CNT_W=2). Stimulus pushes expected output snapshots tagged with the
// clock edge after which they must hold; a monitor checks them on the
// following falling edge.
module tb_pll_reset_seq;

  logic       clk_i;
  logic       rst_ni;
  logic       pll_lock_i;
  logic       clear_i;
  logic       rst_no;
  logic       ready_o;
  logic       lock_lost_o;
  logic [1:0] loss_cnt_o;

  pll_reset_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .LOSS_CNT_W   (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pll_lock_i (pll_lock_i),
    .clear_i    (clear_i),
    .rst_no     (rst_no),
    .ready_o    (ready_o),
    .lock_lost_o(lock_lost_o),
    .loss_cnt_o (loss_cnt_o)
  );

  typedef struct {
    int         at_edge;
    string      name;
    bit         rst;
    bit         lost;
    logic [1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         ecount = 0;
  int         checks = 0;
  int         errors = 0;
  bit         m_lost = 1'b0;
  logic [1:0] m_cnt  = 2'd0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) ecount <= ecount + 1;

  // Monitor: every expectation due by the current edge is compared now.
  always @(negedge clk_i) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].at_edge <= ecount) begin
      e = exp_q.pop_front();
      checks++;
      if (e.at_edge != ecount || rst_no !== e.rst || ready_o !== e.rst ||
          lock_lost_o !== e.lost || loss_cnt_o !== e.cnt) begin
        errors++;
        $display("FAIL %s edge=%0d (due %0d): got rst_no=%b ready_o=%b lock_lost_o=%b loss_cnt_o=%0d, want rst_no=%b ready_o=%b lock_lost_o=%b loss_cnt_o=%0d",
                 e.name, ecount, e.at_edge, rst_no, ready_o, lock_lost_o, loss_cnt_o,
                 e.rst, e.rst, e.lost, e.cnt);
      end
    end
  end

  function automatic void push(int rel, string nm, bit r, bit l, logic [1:0] c);
    exp_t e;
    e.at_edge = ecount + rel;
    e.name    = nm;
    e.rst     = r;
    e.lost    = l;
    e.cnt     = c;
    exp_q.push_back(e);
  endfunction

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Called at a falling edge with the FSM in WAIT_LOCK (or about to be).
  task automatic relock(string nm);
    pll_lock_i = 1'b1;
    push(14, {nm, "_pre"}, 1'b0, m_lost, m_cnt);
    push(15, {nm, "_rel"}, 1'b1, m_lost, m_cnt);
    wait_neg(15);
  endtask

  // Called at a falling edge while in RUN; optional clear on the loss edge.
  task automatic lose_lock(string nm, bit clr_same);
    pll_lock_i = 1'b0;
    push(2, {nm, "_run"}, 1'b1, m_lost, m_cnt);
    m_lost = 1'b1;
    if (clr_same) m_cnt = 2'd1;
    else if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    push(3, {nm, "_drop"}, 1'b0, m_lost, m_cnt);
    wait_neg(2);
    if (clr_same) clear_i = 1'b1;
    wait_neg(1);
    clear_i = 1'b0;
  endtask

  initial begin
    rst_ni     = 1'b0;
    pll_lock_i = 1'b0;
    clear_i    = 1'b0;

    // Reset state, then idle with no lock.
    wait_neg(1);
    push(1, "reset", 1'b0, 1'b0, 2'd0);
    wait_neg(2);
    rst_ni = 1'b1;
    push(3, "idle_no_lock", 1'b0, 1'b0, 2'd0);
    wait_neg(3);

    // 1: clean lock, release after edge 15, stays released.
    relock("t1");
    push(4, "t1_stays_run", 1'b1, 1'b0, 2'd0);
    wait_neg(4);

    // 3: loss in RUN, then re-lock.
    lose_lock("t3", 1'b0);
    relock("t3_relock");

    // 4: repeated losses saturate the counter, then clear.
    for (int i = 0; i < 5; i++) begin
      lose_lock("t4", 1'b0);
      relock("t4_relock");
    end
    clear_i = 1'b1;
    m_lost  = 1'b0;
    m_cnt   = 2'd0;
    push(1, "t4_clear", 1'b1, 1'b0, 2'd0);
    wait_neg(1);
    clear_i = 1'b0;
    push(2, "t4_after_clear", 1'b1, 1'b0, 2'd0);
    wait_neg(2);

    // 5: clear on the loss edge; counter was 1 so an ignored clear would give 2.
    lose_lock("t5_pre", 1'b0);
    relock("t5_pre_relock");
    lose_lock("t5", 1'b1);
    relock("t5_relock");

    // 6a: async reset mid-HOLD clears the loss log immediately.
    lose_lock("t6_pre", 1'b0);
    pll_lock_i = 1'b1;
    push(11, "t6_in_hold", 1'b0, m_lost, m_cnt);
    repeat (12) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    m_lost = 1'b0;
    m_cnt  = 2'd0;
    push(0, "t6_hold_async", 1'b0, 1'b0, 2'd0);
    wait_neg(2);
    rst_ni = 1'b1;
    relock("t6_hold_requal");

    // 6b: async reset mid-RUN drops rst_no before the next edge.
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    push(0, "t6_run_async", 1'b0, 1'b0, 2'd0);
    wait_neg(2);
    rst_ni = 1'b1;

    // 2: one-cycle lock glitch inside the STABLE window restarts qualification.
    push(15, "t2_no_release", 1'b0, 1'b0, 2'd0);
    wait_neg(5);
    pll_lock_i = 1'b0;
    wait_neg(1);
    pll_lock_i = 1'b1;
    push(14, "t2_pre", 1'b0, 1'b0, 2'd0);
    push(15, "t2_rel", 1'b1, 1'b0, 2'd0);
    wait_neg(15);
    push(3, "t2_run", 1'b1, 1'b0, 2'd0);
    wait_neg(3);

    // Drain, bounded.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) wait_neg(1);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      errors = errors + exp_q.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
